// File: rtl/onehot_index_encoder.sv
// Registered one-hot/multi-hot to index encoder: serializes the set bits of a select vector, lowest first.
// Optional macro ONEHOT_STRICT_EN: only exactly-one-hot vectors are accepted, all others are rejected with err.
module onehot_index_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    logic             accept;
    logic             reject;

    // Scanned high-to-low so the last write wins with the lowest set position.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_SCAN);
        busy      = (state_q == S_SCAN);
        out_idx   = lowest_idx(pending_q);
        out_last  = (state_q == S_SCAN) && is_onehot(pending_q);
        err       = err_q;
    end

`ifdef ONEHOT_STRICT_EN
    assign reject = !is_onehot(in_vec);
`else
    assign reject = (in_vec == '0);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        pending_d = in_vec;
                        state_d   = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (out_ready) begin
                    // Clearing the lowest set bit: v & (v-1).
                    pending_d = pending_q & (pending_q - WIDTH'(1));
                    if (out_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Directed self-checking bench for onehot_index_encoder (honours ONEHOT_STRICT_EN when defined).
module tb_onehot_index_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    onehot_index_encoder #(.WIDTH(16), .IDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        total_cnt++;
        if ({in_ready, out_valid, busy, err, out_last, out_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b err=%b last=%b idx=%0d exp rdy=1 others 0",
                     in_ready, out_valid, busy, err, out_last, out_idx);
        else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_vec = 16'h0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_idx, out_last, busy, in_ready} !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0})
            $display("FAIL single_out got vld=%b idx=%0d last=%b busy=%b rdy=%b exp 1 0 1 1 0",
                     out_valid, out_idx, out_last, busy, in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, in_ready, busy} !== {1'b0, 1'b1, 1'b0})
            $display("FAIL single_idle got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_multi();
        logic [3:0] exp_idx [4] = '{4'd0, 4'd2, 4'd13, 4'd15};
        in_valid = 1'b1; in_vec = 16'hA005; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[k] || out_last !== (k == 3))
                $display("FAIL multi_seq[%0d] got vld=%b idx=%0d last=%b exp vld=1 idx=%0d last=%0d",
                         k, out_valid, out_idx, out_last, exp_idx[k], (k == 3));
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL multi_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_vec = 16'h0110; out_ready = 1'b0;
        step();
        // Upstream keeps offering a different vector during SCAN; it must be ignored.
        in_vec = 16'h8000;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 4'd4 || out_last !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL stall_hold[%0d] got vld=%b idx=%0d last=%b rdy=%b exp 1 4 0 0",
                         c, out_valid, out_idx, out_last, in_ready);
            else pass_cnt++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total_cnt++;
        if (out_idx !== 4'd4 || out_last !== 1'b0)
            $display("FAIL stall_first got idx=%0d last=%b exp 4 0", out_idx, out_last);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b1)
            $display("FAIL stall_second got vld=%b idx=%0d last=%b exp 1 8 1", out_valid, out_idx, out_last);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL zero_pre_err got %b exp 0", err);
        else pass_cnt++;
        in_valid = 1'b1; in_vec = 16'h0000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({err, out_valid, in_ready} !== {1'b1, 1'b0, 1'b1})
            $display("FAIL zero_err got err=%b vld=%b rdy=%b exp 1 0 1", err, out_valid, in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({err, out_valid, in_ready} !== {1'b0, 1'b0, 1'b1})
            $display("FAIL zero_clear got err=%b vld=%b rdy=%b exp 0 0 1", err, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        in_valid = 1'b1; in_vec = 16'h8000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd15 || out_last !== 1'b1)
            $display("FAIL top_bit got vld=%b idx=%0d last=%b exp 1 15 1", out_valid, out_idx, out_last);
        else pass_cnt++;
        step();
        in_valid = 1'b1; in_vec = 16'hFFFF;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_last !== (k == 15))
                $display("FAIL full_seq[%0d] got vld=%b idx=%0d last=%b exp vld=1 idx=%0d last=%0d",
                         k, out_valid, out_idx, out_last, k, (k == 15));
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL full_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_vec = 16'h0003; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (out_idx !== 4'd1 || out_last !== 1'b1)
            $display("FAIL b2b_last got idx=%0d last=%b exp 1 1", out_idx, out_last);
        else pass_cnt++;
        step();
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL b2b_ready got %b exp 1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1; in_vec = 16'h0100;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b1)
            $display("FAIL b2b_next got vld=%b idx=%0d last=%b exp 1 8 1", out_valid, out_idx, out_last);
        else pass_cnt++;
        step();
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; in_vec = 16'hFFFF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (out_idx !== 4'(k))
                $display("FAIL midrst_pre[%0d] got idx=%0d exp %0d", k, out_idx, k);
            else pass_cnt++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({out_valid, busy, in_ready, out_last} !== {1'b0, 1'b0, 1'b1, 1'b0})
            $display("FAIL midrst_idle got vld=%b busy=%b rdy=%b last=%b exp 0 0 1 0",
                     out_valid, busy, in_ready, out_last);
        else pass_cnt++;
        in_valid = 1'b1; in_vec = 16'h0040;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd6 || out_last !== 1'b1)
            $display("FAIL midrst_reload got vld=%b idx=%0d last=%b exp 1 6 1", out_valid, out_idx, out_last);
        else pass_cnt++;
        step();
    endtask

`ifdef ONEHOT_STRICT_EN
    task automatic test_strict();
        in_valid = 1'b1; in_vec = 16'h0300; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({err, out_valid, in_ready} !== {1'b1, 1'b0, 1'b1})
            $display("FAIL strict_reject got err=%b vld=%b rdy=%b exp 1 0 1", err, out_valid, in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b1; in_vec = 16'h0200;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd9 || out_last !== 1'b1 || err !== 1'b0)
            $display("FAIL strict_accept got vld=%b idx=%0d last=%b err=%b exp 1 9 1 0",
                     out_valid, out_idx, out_last, err);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL strict_done got vld=%b exp 0", out_valid);
        else pass_cnt++;
    endtask
`else
    task automatic test_multihot();
        in_valid = 1'b1; in_vec = 16'h0300; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b0 || err !== 1'b0)
            $display("FAIL multihot_first got vld=%b idx=%0d last=%b err=%b exp 1 8 0 0",
                     out_valid, out_idx, out_last, err);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 4'd9 || out_last !== 1'b1)
            $display("FAIL multihot_second got vld=%b idx=%0d last=%b exp 1 9 1", out_valid, out_idx, out_last);
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
`ifdef ONEHOT_STRICT_EN
        test_strict();
`else
        test_multihot();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
